// File: rtl/truth_table_scorer_if.sv
// Bus between truth_table_scorer and the harness that owns start, the target table and the candidate.
// The abort_limit/aborted pair exists only when TRUTH_TABLE_SCORER_EARLY_ABORT_EN is defined.
interface truth_table_scorer_if #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int SCORE_W = $clog2(NUM_OUT * 2**NUM_IN + 1)
);
    // start is a one-cycle request; it is taken only when busy=0, otherwise dropped (no queueing).
    logic               start;
    logic [NUM_IN-1:0]  stim;
    logic [NUM_OUT-1:0] dut_out;
    logic               tgt_wr_en;
    logic [NUM_IN-1:0]  tgt_wr_addr;
    logic [NUM_OUT-1:0] tgt_wr_data;
    logic               busy;
    logic               done;
    logic [SCORE_W-1:0] score;
    logic               perfect;
    logic [1:0]         state;
`ifdef TRUTH_TABLE_SCORER_EARLY_ABORT_EN
    logic [SCORE_W-1:0] abort_limit;
    logic               aborted;

    modport master (
        output start, dut_out, tgt_wr_en, tgt_wr_addr, tgt_wr_data, abort_limit,
        input  stim, busy, done, score, perfect, state, aborted
    );
    modport slave (
        input  start, dut_out, tgt_wr_en, tgt_wr_addr, tgt_wr_data, abort_limit,
        output stim, busy, done, score, perfect, state, aborted
    );
`else
    modport master (
        output start, dut_out, tgt_wr_en, tgt_wr_addr, tgt_wr_data,
        input  stim, busy, done, score, perfect, state
    );
    modport slave (
        input  start, dut_out, tgt_wr_en, tgt_wr_addr, tgt_wr_data,
        output stim, busy, done, score, perfect, state
    );
`endif
endinterface

// File: rtl/truth_table_scorer.sv
// Sweeps every input vector into a candidate circuit and accumulates the Hamming distance to a target table.
// Optional early abort on score > abort_limit with TRUTH_TABLE_SCORER_EARLY_ABORT_EN.
module truth_table_scorer #(
    parameter int NUM_IN        = 4,
    parameter int NUM_OUT       = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int SCORE_W       = $clog2(NUM_OUT * 2**NUM_IN + 1)
) (
    input logic clk,
    input logic reset,
    truth_table_scorer_if.slave bus
);
    localparam int DEPTH = 2**NUM_IN;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [NUM_IN-1:0] LAST_IDX = NUM_IN'(DEPTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]         state_q;
    logic [NUM_IN-1:0]  idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_sum;
    logic               accept;
    logic [NUM_OUT-1:0] tgt_mem [DEPTH];

    function automatic logic [SCORE_W-1:0] popcount(input logic [NUM_OUT-1:0] v);
        logic [SCORE_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_OUT; i++) c = c + SCORE_W'(v[i]);
        return c;
    endfunction

    assign accept    = bus.start && (state_q == IDLE || state_q == DONE);
    assign score_sum = score_q + popcount(bus.dut_out ^ tgt_mem[idx_q]);

    // Table is not reset; the busy gate keeps it frozen for the whole sweep.
    always_ff @(posedge clk) begin
        if (bus.tgt_wr_en && !bus.busy) tgt_mem[bus.tgt_wr_addr] <= bus.tgt_wr_data;
    end

`ifdef TRUTH_TABLE_SCORER_EARLY_ABORT_EN
    logic [SCORE_W-1:0] limit_q;
    logic               aborted_q;
    logic               over_limit;
    assign over_limit  = score_sum > limit_q;
    assign bus.aborted = aborted_q;
`else
    logic over_limit;
    assign over_limit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            score_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        state_q <= SETTLE;
                        idx_q   <= '0;
                        cnt_q   <= CNT_LOAD;
                        score_q <= '0;
                    end
                end
                SETTLE: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_q <= SAMPLE;
                end
                SAMPLE: begin
                    score_q <= score_sum;
                    if (over_limit || idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + NUM_IN'(1);
                        cnt_q   <= CNT_LOAD;
                        state_q <= SETTLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef TRUTH_TABLE_SCORER_EARLY_ABORT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            limit_q   <= '0;
            aborted_q <= 1'b0;
        end else if (accept) begin
            limit_q   <= bus.abort_limit;
            aborted_q <= 1'b0;
        end else if (state_q == SAMPLE && over_limit) begin
            aborted_q <= 1'b1;
        end
    end
`endif

    assign bus.stim    = idx_q;
    assign bus.busy    = (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done    = (state_q == DONE);
    assign bus.score   = score_q;
    assign bus.perfect = (state_q == DONE) && (score_q == '0);
    assign bus.state   = state_q;
endmodule

// File: tb/tb_truth_table_scorer.sv
// Self-checking bench for truth_table_scorer at default parameters, with a behavioural candidate circuit.
module tb_truth_table_scorer;
  logic clk;
  logic reset;
  int n_checks;
  int n_fail;
  int mode;
  logic [3:0] mirror [16];
  logic [6:0] exp_q [$];

  truth_table_scorer_if #(.NUM_IN(4), .NUM_OUT(4), .SCORE_W(7)) bus ();

  truth_table_scorer #(.NUM_IN(4), .NUM_OUT(4), .SETTLE_CYCLES(2), .SCORE_W(7)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_f(input logic [3:0] v);
    return {~v[3], v[0] | v[3], v[1] & v[2], v[0] ^ v[1]};
  endfunction

  // mode 0: exact, 1: stuck at 0, 2: output2 flipped at vector 5
  function automatic logic [3:0] cand(input logic [3:0] v, input int m);
    case (m)
      1: return 4'h0;
      2: return (v == 4'd5) ? (ref_f(v) ^ 4'b0100) : ref_f(v);
      default: return ref_f(v);
    endcase
  endfunction

  always_comb bus.dut_out = cand(bus.stim, mode);

  function automatic logic [6:0] expected_score(input int upto);
    logic [6:0] s;
    s = '0;
    for (int v = 0; v <= upto; v++) s = s + 7'($countones(cand(4'(v), mode) ^ mirror[v]));
    return s;
  endfunction

  task automatic load_table(input int kind);
    for (int v = 0; v < 16; v++) begin
      bus.tgt_wr_en   = 1'b1;
      bus.tgt_wr_addr = 4'(v);
      bus.tgt_wr_data = (kind == 0) ? ref_f(4'(v)) : 4'hF;
      mirror[v]       = bus.tgt_wr_data;
      @(posedge clk); #1;
    end
    bus.tgt_wr_en = 1'b0;
  endtask

  // Starts a sweep on the edge after the current one (edge 1) and tracks it to done.
  task automatic run_sweep(input string name, input int exp_done, input int extra_start, input int wr_edge);
    int done_edge;
    logic [6:0] exp;
    exp_q.push_back(expected_score(15));
    @(posedge clk); #1;
    bus.start = 1'b1;
    done_edge = -1;
    for (int n = 1; n <= 120 && done_edge < 0; n++) begin
      @(posedge clk); #1;
      bus.start     = (n + 1 == extra_start);
      bus.tgt_wr_en = (n + 1 == wr_edge);
      bus.tgt_wr_addr = 4'hF;
      bus.tgt_wr_data = ~mirror[15];
      if (n == 1) begin
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_accept: done=%b busy=%b, required done=0 busy=1", name, bus.done, bus.busy);
        end
      end
      if (n < exp_done) begin
        n_checks++;
        if (bus.stim !== 4'((n - 1) / 3)) begin
          n_fail++;
          $display("FAIL %s_stim edge %0d: got %0d required %0d", name, n, bus.stim, (n - 1) / 3);
        end
      end
      if (bus.done === 1'b1) done_edge = n;
    end
    bus.start = 1'b0;
    bus.tgt_wr_en = 1'b0;
    n_checks++;
    if (done_edge != exp_done) begin
      n_fail++;
      $display("FAIL %s_done_edge: got %0d required %0d", name, done_edge, exp_done);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (bus.score !== exp) begin
      n_fail++;
      $display("FAIL %s_score: got %0d required %0d", name, bus.score, exp);
    end
    n_checks++;
    if (bus.perfect !== (exp == 7'd0) || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_flags: perfect=%b busy=%b required perfect=%b busy=0", name, bus.perfect, bus.busy, exp == 7'd0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.score !== 7'd0 || bus.stim !== 4'd0 ||
        bus.perfect !== 1'b0 || bus.state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_values: busy=%b done=%b score=%0d stim=%0d perfect=%b state=%0d, required all 0",
               bus.busy, bus.done, bus.score, bus.stim, bus.perfect, bus.state);
    end
    bus.start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wins_over_start: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_perfect;
    load_table(0);
    mode = 0;
    run_sweep("perfect", 49, -1, -1);
  endtask

  task automatic test_stuck;
    load_table(1);
    mode = 1;
    run_sweep("stuck", 49, -1, -1);
  endtask

  task automatic test_single_fault;
    load_table(0);
    mode = 2;
    run_sweep("single_fault", 49, -1, -1);
  endtask

  task automatic test_reset_mid_sweep;
    logic [6:0] partial;
    load_table(0);
    mode = 1;
    partial = expected_score(5);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    n_checks++;
    if (bus.score !== partial || partial == 7'd0) begin
      n_fail++;
      $display("FAIL mid_partial_score: got %0d required %0d (nonzero)", bus.score, partial);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.score !== 7'd0 || bus.stim !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: busy=%b done=%b score=%0d stim=%0d required all 0",
               bus.busy, bus.done, bus.score, bus.stim);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mode = 2;
    run_sweep("after_reset", 49, -1, -1);
  endtask

  task automatic test_protocol;
    load_table(0);
    mode = 2;
    run_sweep("protocol", 49, 10, 15);
    run_sweep("readback", 49, -1, -1);
  endtask

  task automatic test_back_to_back;
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done_before: got %b required 1", bus.done);
    end
    mode = 0;
    run_sweep("b2b_first", 49, -1, -1);
    mode = 1;
    run_sweep("b2b_second", 49, -1, -1);
  endtask

`ifdef TRUTH_TABLE_SCORER_EARLY_ABORT_EN
  task automatic test_early_abort;
    load_table(1);
    mode = 1;
    bus.abort_limit = 7'd3;
    exp_q.push_back(7'd4);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort_limit = 7'd127;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b1 || bus.aborted !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flags edge 4: done=%b aborted=%b busy=%b required 1 1 0", bus.done, bus.aborted, bus.busy);
    end
    n_checks++;
    if (bus.score !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL abort_score: got %0d required 4", bus.score);
    end
    mode = 0;
    load_table(0);
    run_sweep("after_abort", 49, -1, -1);
    n_checks++;
    if (bus.aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_cleared: got %b required 0", bus.aborted);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail = 0;
    mode = 0;
    bus.start = 1'b0;
    bus.tgt_wr_en = 1'b0;
    bus.tgt_wr_addr = '0;
    bus.tgt_wr_data = '0;
`ifdef TRUTH_TABLE_SCORER_EARLY_ABORT_EN
    bus.abort_limit = 7'd127;
`endif
    test_reset;
    test_perfect;
    test_stuck;
    test_single_fault;
    test_reset_mid_sweep;
    test_protocol;
    test_back_to_back;
`ifdef TRUTH_TABLE_SCORER_EARLY_ABORT_EN
    test_early_abort;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/truth_table_scorer.md
Name: truth_table_scorer

Overview:
- Sequential fitness evaluator for evolved combinational candidates such as the fourBool circuit, generalised to NUM_IN inputs and NUM_OUT outputs.
- Sweeps all 2^NUM_IN input vectors into the candidate and waits SETTLE_CYCLES clocks per vector so gate delays settle.
- Samples the candidate outputs and compares them bitwise against a loadable target truth table.
- Accumulates a Hamming mismatch score, which the evolution loop reads as fitness.

Parameters:
- NUM_IN, 4, candidate input count; table depth is 2^NUM_IN (1..10).
- NUM_OUT, 4, candidate output count; table entry width (1..16).
- SETTLE_CYCLES, 2, clocks held per vector before sampling; minimum 1.
- SCORE_W, $clog2(NUM_OUT*2**NUM_IN+1), score width (7 at defaults).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored while busy.
- stim  out  NUM_IN  vector driven to the candidate; stim[0] drives input0.
- dut_out  in  NUM_OUT  candidate outputs; dut_out[0] is output0.
- tgt_wr_en  in  1  target table write strobe.
- tgt_wr_addr  in  NUM_IN  target table row, equal to the input vector value.
- tgt_wr_data  in  NUM_OUT  expected outputs for that row.
- busy  out  1  high while a sweep is in progress.
- done  out  1  level; high from sweep end until the next accepted start.
- score  out  SCORE_W  total mismatched output bits.
- perfect  out  1  done & (score==0).

Behaviour:
- Reset (async assert, sync release): state IDLE; stim=0, busy=0, done=0, score=0, perfect=0, idx=0, settle counter=0. Target table contents are not reset and are retained.
- Target table: 2^NUM_IN x NUM_OUT registers, written synchronously when tgt_wr_en=1 and busy=0. Writes while busy are dropped, so the table is stable during a sweep.
- State machine: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE). DONE -> SETTLE on start.
- Start accepted (IDLE or DONE, start=1):
  - next cycle: state=SETTLE, idx=0, stim=0, score=0, done=0, busy=1, counter=SETTLE_CYCLES.
  - A write in the same cycle as an accepted start takes effect.
- SETTLE: decrement counter each cycle; move to SAMPLE after SETTLE_CYCLES cycles in SETTLE. stim is held constant.
- SAMPLE (one cycle):
  - score += popcount(dut_out ^ table[idx]).
  - If idx==2^NUM_IN-1: go to DONE; busy=0, done=1.
  - Otherwise: idx+1, stim=idx+1, return to SETTLE with the counter reloaded.
- Each vector occupies SETTLE_CYCLES+1 cycles. done rises 2^NUM_IN*(SETTLE_CYCLES+1)+1 edges after the start edge; this is 49 at defaults.
- idx never wraps within a sweep. Vectors are applied in ascending order 0..2^NUM_IN-1.
- score saturates by construction (its maximum fits SCORE_W); there is no overflow path.
- start while busy: ignored, no restart. start and reset together: reset wins.
- Reset mid-sweep: immediate return to IDLE with reset values; no partial score is retained.
- dut_out is sampled only in SAMPLE; X/changes at other times have no effect.

Optional Feature:
- Macro: TRUTH_TABLE_SCORER_EARLY_ABORT_EN.
- Defined:
  - Adds input abort_limit (SCORE_W) and output aborted (1).
  - When a SAMPLE makes score > abort_limit, go straight to DONE; busy=0, done=1, aborted=1.
  - score holds the value that crossed the limit.
  - aborted clears on accepted start or reset.
  - abort_limit is sampled at start acceptance.
- Not defined: no extra ports; every sweep runs all vectors.

Test Plan:
- Perfect candidate: load target with output3=~input3 and other outputs from a bench model that matches the candidate exactly; pulse start -> done rises on edge 49, score=0, perfect=1, stim steps 0..15.
- Stuck candidate: dut_out tied 4'h0, target all 4'hF -> score=64, perfect=0.
- Single fault: bench model flips output2 only when stim==5 -> score=1.
- Reset mid-sweep: assert reset at edge 20 while score>0 -> busy, done, score, and stim are all 0 at once. A fresh start then gives the full 49-cycle run with the correct score, and the table is unchanged.
- Protocol: start pulsed at edge 10 of a sweep is ignored (done still at 49). A tgt_wr_en at edge 15 does not change the table (readback sweep unchanged). Back-to-back start while done=1 clears done next cycle.
- With TRUTH_TABLE_SCORER_EARLY_ABORT_EN, abort_limit=3 and a stuck candidate with 4 mismatches per vector -> aborted=1, score=4, done after the first SAMPLE, i.e. edge 4.
